// File: rtl/cache_pkg.sv
// Shared cache types and widths for the L1 storage block and its snooper.
// Address layout: [INDEX_W-1:0] is the L1 index, the upper TAG_W bits are the tag.
package cache_pkg;
  localparam int ADDR_W      = 6;
  localparam int INDEX_W     = 2;
  localparam int TAG_W       = 4;
  localparam int OFFSET_W    = 0;
  localparam int CACHELINE_W = 1;
  localparam int CPU_CORES   = 4;
  localparam int CORE_W      = $clog2(CPU_CORES);

  typedef enum logic [2:0] {
    ST_I = 3'd0,
    ST_S = 3'd1,
    ST_E = 3'd2,
    ST_O = 3'd3,
    ST_M = 3'd4
  } moesi_t;

  typedef struct packed {
    moesi_t                 state;
    logic [TAG_W-1:0]       tag;
    logic [CACHELINE_W-1:0] data;
  } l1_cacheline_t;

  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_WB   = 2'd3
  } bus_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } snoop_state_t;
endpackage

// File: rtl/l1_snooper_if.sv
// Snoop bus: request channel (bus_valid/bus_ready) and response channel (resp_valid/resp_ready).
// Handshakes: a beat transfers on a rising edge where valid && ready; the sender holds its
// payload stable from valid rising until that edge, and valid never waits on ready.
interface l1_snooper_if;
  import cache_pkg::*;

  logic                   bus_valid;
  logic                   bus_ready;
  bus_req_t               bus_req;
  logic [ADDR_W-1:0]      bus_addr;
  logic [CORE_W-1:0]      bus_src;
  logic                   resp_valid;
  logic                   resp_ready;
  logic                   resp_shared;
  logic                   resp_flush;
  logic [CACHELINE_W-1:0] resp_data;

  modport master (
    output bus_valid, bus_req, bus_addr, bus_src, resp_ready,
    input  bus_ready, resp_valid, resp_shared, resp_flush, resp_data
  );

  modport slave (
    input  bus_valid, bus_req, bus_addr, bus_src, resp_ready,
    output bus_ready, resp_valid, resp_shared, resp_flush, resp_data
  );
endinterface

// File: rtl/moesi_snoop_xfer.sv
// MOESI transition taken by a remote snoop hit: next state, dirty-data flush, and
// protocol error (an upgrade request can never legally hit an exclusive-class line).
module moesi_snoop_xfer
  import cache_pkg::*;
(
  input  moesi_t   cur,
  input  bus_req_t req,
  output moesi_t   nxt,
  output logic     flush,
  output logic     err
);
  always_comb begin
    nxt   = cur;
    flush = 1'b0;
    err   = 1'b0;
    case (req)
      BUS_RD: begin
        case (cur)
          ST_M:    begin nxt = ST_O; flush = 1'b1; end
          ST_O:    flush = 1'b1;
          ST_E:    nxt = ST_S;
          default: ;
        endcase
      end
      BUS_RDX: begin
        nxt   = ST_I;
        flush = (cur == ST_M) || (cur == ST_O);
      end
      BUS_UPGR: begin
        nxt = ST_I;
        err = (cur == ST_M) || (cur == ST_E);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/l1_snooper.sv
// Per-core snooper: accepts a bus transaction, looks up the L1 line for one cycle,
// applies the MOESI snoop transition and returns a registered snoop response.
module l1_snooper
  import cache_pkg::*;
#(
  parameter int CORE_ID = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  l1_snooper_if.slave        bus,
  output logic               proto_err,
  output logic [ADDR_W-1:0]  snoop_addr,
  input  l1_cacheline_t      snoop_line_in,
  output l1_cacheline_t      snoop_line_out,
  output logic               snoop_valid,
  output snoop_state_t       state_dbg
);
  snoop_state_t           state;
  bus_req_t               req_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   self_q;
  logic                   shared_q;
  logic                   flush_q;
  logic [CACHELINE_W-1:0] data_q;

  moesi_t nxt_st;
  logic   x_flush;
  logic   x_err;
  logic   in_lookup;
  logic   hit;

  moesi_snoop_xfer u_xfer (
    .cur   (snoop_line_in.state),
    .req   (req_q),
    .nxt   (nxt_st),
    .flush (x_flush),
    .err   (x_err)
  );

  assign in_lookup = (state == LOOKUP);
  assign hit = in_lookup && !self_q && (snoop_line_in.state != ST_I) &&
               (snoop_line_in.tag == addr_q[ADDR_W-1 -: TAG_W]);

  // The L1 read is combinational, so the write-back and error pulse must be too.
  assign snoop_addr  = in_lookup ? addr_q : '0;
  assign snoop_valid = hit && (nxt_st != snoop_line_in.state);
  assign proto_err   = hit && x_err;

  always_comb begin
    snoop_line_out       = snoop_line_in;
    snoop_line_out.state = nxt_st;
  end

  assign bus.bus_ready   = (state == IDLE);
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_shared = shared_q;
  assign bus.resp_flush  = flush_q;
  assign bus.resp_data   = data_q;
  assign state_dbg       = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      req_q    <= BUS_RD;
      addr_q   <= '0;
      self_q   <= 1'b0;
      shared_q <= 1'b0;
      flush_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.bus_valid) begin
            req_q  <= bus.bus_req;
            addr_q <= bus.bus_addr;
            self_q <= (bus.bus_src == CORE_W'(CORE_ID));
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          shared_q <= hit;
          flush_q  <= hit && x_flush;
          data_q   <= (hit && x_flush) ? snoop_line_in.data : '0;
          state    <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_snooper.sv
// Directed bench for l1_snooper: a small L1 array model behind the snoop port and
// hand-computed expectations for each snoop transaction.
module tb_l1_snooper;
  import cache_pkg::*;

  logic          clk;
  logic          reset_n;
  logic          proto_err;
  logic [5:0]    snoop_addr;
  l1_cacheline_t snoop_line_in;
  l1_cacheline_t snoop_line_out;
  logic          snoop_valid;
  snoop_state_t  state_dbg;

  l1_snooper_if bus_if ();

  l1_snooper #(.CORE_ID(0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus_if),
    .proto_err      (proto_err),
    .snoop_addr     (snoop_addr),
    .snoop_line_in  (snoop_line_in),
    .snoop_line_out (snoop_line_out),
    .snoop_valid    (snoop_valid),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // L1 storage model
  l1_cacheline_t l1 [4];
  logic          pre_en;
  logic [1:0]    pre_idx;
  l1_cacheline_t pre_line;

  assign snoop_line_in = l1[snoop_addr[1:0]];

  always @(posedge clk) begin
    if (snoop_valid)  l1[snoop_addr[1:0]] <= snoop_line_out;
    else if (pre_en)  l1[pre_idx] <= pre_line;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [1:0] idx, input moesi_t st, input logic [3:0] tag,
                         input logic dat);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_idx  = idx;
    pre_line = '{state: st, tag: tag, data: dat};
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // One full transaction; exp_st is the line state expected in L1 after the lookup.
  task automatic run_txn(input string tag, input bus_req_t req, input logic [5:0] addr,
                         input logic [1:0] src, input logic exp_sv, input moesi_t exp_st,
                         input logic exp_sh, input logic exp_fl, input logic exp_dat,
                         input logic exp_err, input int stall);
    @(negedge clk);
    check({tag, ".bus_ready"}, 32'(bus_if.bus_ready), 32'd1);
    bus_if.bus_valid = 1'b1;
    bus_if.bus_req   = req;
    bus_if.bus_addr  = addr;
    bus_if.bus_src   = src;
    @(posedge clk);
    #1 bus_if.bus_valid = 1'b0;
    @(negedge clk);
    check({tag, ".lk_state"}, 32'(state_dbg), 32'(LOOKUP));
    check({tag, ".snoop_addr"}, 32'(snoop_addr), 32'(addr));
    check({tag, ".snoop_valid"}, 32'(snoop_valid), 32'(exp_sv));
    check({tag, ".proto_err"}, 32'(proto_err), 32'(exp_err));
    if (exp_sv) check({tag, ".line_out"}, 32'(snoop_line_out.state), 32'(exp_st));
    @(negedge clk);
    check({tag, ".resp_valid"}, 32'(bus_if.resp_valid), 32'd1);
    check({tag, ".shared"}, 32'(bus_if.resp_shared), 32'(exp_sh));
    check({tag, ".flush"}, 32'(bus_if.resp_flush), 32'(exp_fl));
    check({tag, ".data"}, 32'(bus_if.resp_data), 32'(exp_dat));
    check({tag, ".resp_quiet"}, 32'({proto_err, snoop_valid, snoop_addr}), 32'd0);
    check({tag, ".l1_state"}, 32'(l1[addr[1:0]].state), 32'(exp_st));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ".stall_valid"}, 32'(bus_if.resp_valid), 32'd1);
      check({tag, ".stall_ready"}, 32'(bus_if.bus_ready), 32'd0);
      check({tag, ".stall_fields"},
            32'({bus_if.resp_shared, bus_if.resp_flush, bus_if.resp_data}),
            32'({exp_sh, exp_fl, exp_dat}));
    end
    bus_if.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus_if.resp_ready = 1'b0;
  endtask

  initial begin
    reset_n           = 1'b0;
    pre_en            = 1'b0;
    pre_idx           = 2'd0;
    pre_line          = '0;
    bus_if.bus_valid  = 1'b0;
    bus_if.bus_req    = BUS_RD;
    bus_if.bus_addr   = 6'd0;
    bus_if.bus_src    = 2'd0;
    bus_if.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) l1[i] = '0;

    repeat (3) @(negedge clk);
    check("rst.state", 32'(state_dbg), 32'(IDLE));
    check("rst.bus_ready", 32'(bus_if.bus_ready), 32'd1);
    check("rst.resp", 32'({bus_if.resp_valid, bus_if.resp_shared, bus_if.resp_flush,
                           bus_if.resp_data}), 32'd0);
    check("rst.snoop", 32'({proto_err, snoop_valid, snoop_addr}), 32'd0);
    reset_n = 1'b1;

    // M hit on read: owner keeps dirty copy as O and flushes it
    preload(2'd1, ST_M, 4'd3, 1'b1);
    run_txn("rd_m", BUS_RD, 6'h0D, 2'd2, 1'b1, ST_O, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    // S hit on read-exclusive: invalidate, nothing to flush
    preload(2'd0, ST_S, 4'd5, 1'b0);
    run_txn("rdx_s", BUS_RDX, 6'h14, 2'd1, 1'b1, ST_I, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // E hit on upgrade: illegal, still invalidates
    preload(2'd2, ST_E, 4'd1, 1'b1);
    run_txn("upgr_e", BUS_UPGR, 6'h06, 2'd3, 1'b1, ST_I, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    // tag miss, self request, and write-back hit
    preload(2'd3, ST_M, 4'd2, 1'b1);
    run_txn("rd_miss", BUS_RD, 6'h1F, 2'd2, 1'b0, ST_M, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_txn("rd_self", BUS_RD, 6'h0B, 2'd0, 1'b0, ST_M, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_txn("wb_hit", BUS_WB, 6'h0B, 2'd1, 1'b0, ST_M, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // O line from the first transaction: read keeps O, read-exclusive drops it
    run_txn("rd_o", BUS_RD, 6'h0D, 2'd3, 1'b0, ST_O, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    run_txn("rdx_o", BUS_RDX, 6'h0D, 2'd2, 1'b1, ST_I, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    // upgrade on a shared line is legal
    preload(2'd0, ST_S, 4'd5, 1'b1);
    run_txn("upgr_s", BUS_UPGR, 6'h14, 2'd2, 1'b1, ST_I, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // E -> S with a 4-cycle response stall
    preload(2'd0, ST_E, 4'd5, 1'b1);
    run_txn("rd_e_stall", BUS_RD, 6'h14, 2'd1, 1'b1, ST_S, 1'b1, 1'b0, 1'b0, 1'b0, 4);

    // reset pulsed in LOOKUP aborts the transaction
    preload(2'd2, ST_M, 4'd1, 1'b1);
    @(negedge clk);
    bus_if.bus_valid = 1'b1;
    bus_if.bus_req   = BUS_RDX;
    bus_if.bus_addr  = 6'h06;
    bus_if.bus_src   = 2'd1;
    @(posedge clk);
    #1;
    bus_if.bus_valid = 1'b0;
    reset_n          = 1'b0;
    #1;
    check("abort.snoop_valid", 32'(snoop_valid), 32'd0);
    check("abort.resp_valid", 32'(bus_if.resp_valid), 32'd0);
    check("abort.state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("abort.bus_ready", 32'(bus_if.bus_ready), 32'd1);
    @(negedge clk);
    check("abort.idle", 32'(state_dbg), 32'(IDLE));
    check("abort.no_resp", 32'(bus_if.resp_valid), 32'd0);
    check("abort.l1_kept", 32'(l1[2].state), 32'(ST_M));

    // the aborted line is still intact and snoopable afterwards
    run_txn("post_abort", BUS_RDX, 6'h06, 2'd1, 1'b1, ST_I, 1'b1, 1'b1, 1'b1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
